// File: rtl/pe_row_pkg.sv
// Shared types and widths for the pe_row_v2 systolic row: datapath widths,
// the capture/requant stage records and the output saturation helper.
package pe_row_pkg;

  localparam int ACT_WIDTH     = 8;
  localparam int WGT_WIDTH     = 8;
  localparam int ACC_EXT       = 10;
  localparam int QNT_WIDTH     = 20;
  localparam int SHIFT_WIDTH   = 5;
  localparam int FM_WIDTH      = 8;
  localparam int PSUM_WIDTH    = ACT_WIDTH + WGT_WIDTH + ACC_EXT;
  localparam int PROD_WIDTH    = PSUM_WIDTH + QNT_WIDTH + 1;
  // Wide enough for any practical row; the top slices it to $clog2(NUM_PE).
  localparam int IDX_MAX_WIDTH = 8;

  // Finished accumulation waiting for the scale multiply.
  typedef struct packed {
    logic signed [PSUM_WIDTH-1:0] psum;
    logic [IDX_MAX_WIDTH-1:0]     idx;
    logic                         vld;
  } cap_t;

  // Scaled product waiting for shift / zero point / saturate.
  typedef struct packed {
    logic signed [PROD_WIDTH-1:0] prod;
    logic [IDX_MAX_WIDTH-1:0]     idx;
    logic                         vld;
  } stage_t;

  // Clamp a signed requant result into the unsigned feature range.
  function automatic logic [FM_WIDTH-1:0] saturate(input logic signed [PROD_WIDTH:0] x);
    logic signed [PROD_WIDTH:0] fm_max;
    fm_max = (PROD_WIDTH+1)'((2 ** FM_WIDTH) - 1);
    if (x < 0)           return '0;
    else if (x > fm_max) return '1;
    else                 return x[FM_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pe_row_v2_if.sv
// Activation-in / result-out handshake bundle of pe_row_v2.
// master = feeder/consumer side, slave = the row itself.
interface pe_row_v2_if import pe_row_pkg::*; #(
  parameter int NUM_PE = 16
) ();

  localparam int IDX_WIDTH = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic                        in_vld;
  logic                        in_rdy;
  logic [ACT_WIDTH-1:0]        in_act;
  logic                        in_last;
  logic [WGT_WIDTH*NUM_PE-1:0] in_wgt;

  logic                        out_vld;
  logic                        out_rdy;
  logic [FM_WIDTH-1:0]         out_fm;
  logic [IDX_WIDTH-1:0]        out_idx;

  modport master (
    output in_vld, in_act, in_last, in_wgt, out_rdy,
    input  in_rdy, out_vld, out_fm, out_idx
  );

  modport slave (
    input  in_vld, in_act, in_last, in_wgt, out_rdy,
    output in_rdy, out_vld, out_fm, out_idx
  );

endinterface

// File: rtl/pe_mac.sv
// One output-stationary MAC cell: skew registers for act/vld/last, the
// forwarded weight, the accumulator and a capture request on the last beat.
module pe_mac import pe_row_pkg::*; (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift_en,
  input  logic [ACT_WIDTH-1:0]         prev_act,
  input  logic                         prev_vld,
  input  logic                         prev_last,
  input  logic signed [WGT_WIDTH-1:0]  wgt,
  output logic [ACT_WIDTH-1:0]         act_q,
  output logic                         vld_q,
  output logic                         last_q,
  output logic [WGT_WIDTH-1:0]         wgt_q,
  output logic                         cap_req,
  output logic signed [PSUM_WIDTH-1:0] cap_psum
);

  localparam int MUL_WIDTH = ACT_WIDTH + WGT_WIDTH + 1;

  logic signed [PSUM_WIDTH-1:0] acc;
  logic                         first;
  logic signed [MUL_WIDTH-1:0]  prod;
  logic signed [PSUM_WIDTH-1:0] base;
  logic signed [PSUM_WIDTH-1:0] sum;

  // Activation is unsigned, so it is zero-extended before the signed multiply.
  assign prod     = MUL_WIDTH'($signed({1'b0, prev_act})) * MUL_WIDTH'(wgt);
  assign base     = first ? '0 : acc;
  assign sum      = base + PSUM_WIDTH'(prod);
  assign cap_req  = shift_en & prev_vld & prev_last;
  assign cap_psum = sum;

  // Skew registers and accumulator advance together whenever the row shifts.
  // NOTE: non-blocking assignments so every register samples pre-edge values;
  // blocking ones here would let a beat race through several cells in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      wgt_q  <= '0;
      acc    <= '0;
      first  <= 1'b1;
    end else if (shift_en) begin
      act_q  <= prev_act;
      vld_q  <= prev_vld;
      last_q <= prev_last;
      wgt_q  <= wgt;
      if (prev_vld) begin
        acc   <= sum;
        first <= prev_last;
      end
    end
  end

endmodule

// File: rtl/pe_row_v2.sv
// Systolic PE row with requantisation and a result FIFO.
// Optional: define PE_ROW_ROUND_EN to round half up before the requant shift;
// without it the shift truncates toward minus infinity.
module pe_row_v2 import pe_row_pkg::*; #(
  parameter int NUM_PE      = 16,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [QNT_WIDTH-1:0]        cfg_scale,
  input  logic [SHIFT_WIDTH-1:0]      cfg_shift,
  input  logic [FM_WIDTH-1:0]         cfg_zp,
  pe_row_v2_if.slave                  bus,
  output logic [ACT_WIDTH-1:0]        out_act_right,
  output logic                        out_vld_right,
  output logic                        out_last_right,
  output logic [WGT_WIDTH*NUM_PE-1:0] out_wgt_below,
  output logic                        err_len,
  output logic                        busy
);

  localparam int IDX_WIDTH  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int PTR_WIDTH  = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam int CNT_WIDTH  = $clog2(OFIFO_DEPTH + 1);
  localparam int OCC_WIDTH  = CNT_WIDTH + 1;
  localparam int BEAT_WIDTH = $clog2(NUM_PE + 1);

  // ---------------- skew chain and MAC cells ----------------
  logic [ACT_WIDTH-1:0]         act_chain [NUM_PE+1];
  logic [NUM_PE:0]              vld_chain;
  logic [NUM_PE:0]              last_chain;
  logic [NUM_PE-1:0]            cap_req;
  logic signed [PSUM_WIDTH-1:0] cap_psum [NUM_PE];
  logic                         row_en;

  assign act_chain[0]  = bus.in_act;
  assign vld_chain[0]  = bus.in_vld;
  assign last_chain[0] = bus.in_last;

  for (genvar j = 0; j < NUM_PE; j++) begin : g_pe
    pe_mac u_mac (
      .clk       (clk),
      .rst       (rst),
      .shift_en  (row_en),
      .prev_act  (act_chain[j]),
      .prev_vld  (vld_chain[j]),
      .prev_last (last_chain[j]),
      .wgt       (bus.in_wgt[j*WGT_WIDTH +: WGT_WIDTH]),
      .act_q     (act_chain[j+1]),
      .vld_q     (vld_chain[j+1]),
      .last_q    (last_chain[j+1]),
      .wgt_q     (out_wgt_below[j*WGT_WIDTH +: WGT_WIDTH]),
      .cap_req   (cap_req[j]),
      .cap_psum  (cap_psum[j])
    );
  end

  assign out_act_right  = act_chain[NUM_PE];
  assign out_vld_right  = vld_chain[NUM_PE];
  assign out_last_right = last_chain[NUM_PE];

  // ---------------- capture select ----------------
  cap_t cap_next, cap;

  // Highest-index request wins; a colliding lower-index capture is dropped.
  // NOTE: every field gets a default before the loop so no latch is inferred.
  always_comb begin
    cap_next = '0;
    for (int j = 0; j < NUM_PE; j++) begin
      if (cap_req[j]) begin
        cap_next.vld  = 1'b1;
        cap_next.psum = cap_psum[j];
        cap_next.idx  = IDX_MAX_WIDTH'(j);
      end
    end
  end

  // ---------------- requant pipeline ----------------
  stage_t s1;

  // Capture register and scale multiply; never stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap <= '0;
      s1  <= '0;
    end else begin
      cap <= cap_next;
      s1  <= '{prod: PROD_WIDTH'($signed(cap.psum)) * PROD_WIDTH'($signed({1'b0, cfg_scale})),
               idx:  cap.idx,
               vld:  cap.vld};
    end
  end

  logic signed [PROD_WIDTH:0] ext, half, biased, shifted, with_zp;
  logic [FM_WIDTH-1:0]        fm_next;

  // Stage 2: optional rounding bias, arithmetic shift, zero point, clamp.
  always_comb begin
`ifdef PE_ROW_ROUND_EN
    half = '0;
    if (cfg_shift != '0) half = (PROD_WIDTH+1)'(1) << (cfg_shift - SHIFT_WIDTH'(1));
`else
    half = '0;
`endif
    ext     = (PROD_WIDTH+1)'(s1.prod);
    biased  = ext + half;
    shifted = biased >>> cfg_shift;
    with_zp = shifted + (PROD_WIDTH+1)'($signed({1'b0, cfg_zp}));
    fm_next = saturate(with_zp);
  end

  // ---------------- output FIFO ----------------
  logic [FM_WIDTH-1:0]  fm_mem  [OFIFO_DEPTH];
  logic [IDX_WIDTH-1:0] idx_mem [OFIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0] fifo_count;
  logic                 push, pop;

  assign push = s1.vld;
  assign pop  = bus.out_vld & bus.out_rdy;

  // FIFO storage, pointers and occupancy.
  // NOTE: the storage is reset on purpose: it is only a few entries and
  // out_fm/out_idx read the head directly, so they must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OFIFO_DEPTH; i++) begin
        fm_mem[i]  <= '0;
        idx_mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fm_mem[wr_ptr]  <= fm_next;
        idx_mem[wr_ptr] <= s1.idx[IDX_WIDTH-1:0];
        wr_ptr <= (wr_ptr == PTR_WIDTH'(OFIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_WIDTH'(OFIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_WIDTH'(1);
        2'b01:   fifo_count <= fifo_count - CNT_WIDTH'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.out_vld = (fifo_count != '0);
  assign bus.out_fm  = fm_mem[rd_ptr];
  assign bus.out_idx = idx_mem[rd_ptr];

  // Admission control reserves a FIFO slot for every result already in flight,
  // so the never-stalling requant path can always write.
  logic [OCC_WIDTH-1:0] occupancy;
  assign occupancy = OCC_WIDTH'(fifo_count) + OCC_WIDTH'(cap.vld) + OCC_WIDTH'(s1.vld);
  assign row_en     = occupancy < OCC_WIDTH'(OFIFO_DEPTH);
  assign bus.in_rdy = row_en;

  assert property (@(posedge clk) disable iff (rst) !(push && fifo_count == CNT_WIDTH'(OFIFO_DEPTH)));

  // ---------------- accumulation length check ----------------
  logic [BEAT_WIDTH-1:0] beat_cnt;

  // Count accepted beats at PE0 since the previous last; short groups set err_len.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      err_len  <= 1'b0;
    end else if (bus.in_vld && row_en) begin
      if (bus.in_last) begin
        if (beat_cnt < BEAT_WIDTH'(NUM_PE - 1)) err_len <= 1'b1;
        beat_cnt <= '0;
      end else if (beat_cnt != BEAT_WIDTH'(NUM_PE)) begin
        beat_cnt <= beat_cnt + BEAT_WIDTH'(1);
      end
    end
  end

  assign busy = (|vld_chain[NUM_PE:1]) | cap.vld | s1.vld | (fifo_count != '0);

endmodule

// File: tb/tb_pe_row_v2.sv
// Directed self-checking bench for pe_row_v2 with a 4-PE row.
module tb_pe_row_v2;
  import pe_row_pkg::*;

  localparam int NPE   = 4;
  localparam int DEPTH = 4;
`ifdef PE_ROW_ROUND_EN
  localparam int RND_OF_3 = 2;
`else
  localparam int RND_OF_3 = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [QNT_WIDTH-1:0]     cfg_scale;
  logic [SHIFT_WIDTH-1:0]   cfg_shift;
  logic [FM_WIDTH-1:0]      cfg_zp;
  logic [ACT_WIDTH-1:0]     out_act_right;
  logic                     out_vld_right, out_last_right;
  logic [WGT_WIDTH*NPE-1:0] out_wgt_below;
  logic                     err_len, busy;

  pe_row_v2_if #(.NUM_PE(NPE)) bus ();

  pe_row_v2 #(.NUM_PE(NPE), .OFIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_scale      (cfg_scale),
    .cfg_shift      (cfg_shift),
    .cfg_zp         (cfg_zp),
    .bus            (bus),
    .out_act_right  (out_act_right),
    .out_vld_right  (out_vld_right),
    .out_last_right (out_last_right),
    .out_wgt_below  (out_wgt_below),
    .err_len        (err_len),
    .busy           (busy)
  );

  int checks   = 0;
  int failures = 0;
  int results[$];

  // Record every popped result as idx*256 + fm, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && bus.out_vld && bus.out_rdy)
      results.push_back(int'(bus.out_idx) * 256 + int'(bus.out_fm));
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [ACT_WIDTH-1:0] a, input logic l);
    int n;
    n = 0;
    bus.in_vld  = 1'b1;
    bus.in_act  = a;
    bus.in_last = l;
    while (!bus.in_rdy && n < 300) begin
      tick();
      n++;
    end
    if (n == 300) check("beat_accept_timeout", 64'(bus.in_rdy), 64'(1));
    tick();
    bus.in_vld  = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic group4(input int a0, input int a1, input int a2, input int a3);
    beat(ACT_WIDTH'(a0), 1'b0);
    beat(ACT_WIDTH'(a1), 1'b0);
    beat(ACT_WIDTH'(a2), 1'b0);
    beat(ACT_WIDTH'(a3), 1'b1);
  endtask

  task automatic drain(input int n, input string tag);
    int k;
    k = 0;
    while (busy && k < 500) begin
      tick();
      k++;
    end
    check($sformatf("%s_idle", tag), 64'(busy), 64'(0));
    check($sformatf("%s_count", tag), 64'(results.size()), 64'(n));
  endtask

  task automatic expect_res(input int i, input int idx, input int fm, input string tag);
    int obs;
    obs = (results.size() > i) ? results[i] : -1;
    check($sformatf("%s_r%0d", tag, i), 64'(obs), 64'(idx * 256 + fm));
  endtask

  initial begin
    rst         = 1'b1;
    bus.in_vld  = 1'b0;
    bus.in_act  = '0;
    bus.in_last = 1'b0;
    bus.in_wgt  = {8'd4, 8'd3, 8'd2, 8'd1};
    bus.out_rdy = 1'b1;
    cfg_scale   = 20'd1;
    cfg_shift   = 5'd0;
    cfg_zp      = 8'd0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_vld", 64'(bus.out_vld), 64'(0));
    check("rst_in_rdy", 64'(bus.in_rdy), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err_len", 64'(err_len), 64'(0));
    check("rst_out_fm", 64'(bus.out_fm), 64'(0));
    check("rst_out_idx", 64'(bus.out_idx), 64'(0));
    check("rst_act_right", 64'({out_act_right, out_vld_right, out_last_right}), 64'(0));
    check("rst_wgt_below", 64'(out_wgt_below), 64'(0));

    // Basic sums: acts=1, wgt_j=j+1, L=4
    group4(1, 1, 1, 1);
    check("wgt_below_fwd", 64'(out_wgt_below), 64'({8'd4, 8'd3, 8'd2, 8'd1}));
    drain(4, "basic");
    for (int j = 0; j < NPE; j++) expect_res(j, j, 4 * (j + 1), "basic");
    results.delete();

    // psum=3, shift=1: rounding vs truncation
    cfg_shift  = 5'd1;
    bus.in_wgt = {4{8'd1}};
    group4(1, 1, 1, 0);
    drain(4, "round");
    for (int j = 0; j < NPE; j++) expect_res(j, j, RND_OF_3, "round");
    results.delete();
    cfg_shift = 5'd0;

    // psum=-5 clamps to 0
    bus.in_wgt = {4{8'hFF}};
    group4(5, 0, 0, 0);
    drain(4, "sat_lo");
    for (int j = 0; j < NPE; j++) expect_res(j, j, 0, "sat_lo");
    results.delete();

    // psum=300 clamps to 255
    bus.in_wgt = {4{8'd1}};
    group4(100, 100, 100, 0);
    drain(4, "sat_hi");
    for (int j = 0; j < NPE; j++) expect_res(j, j, 255, "sat_hi");
    results.delete();

    // psum=0 with zero point 7
    cfg_zp = 8'd7;
    group4(0, 0, 0, 0);
    drain(4, "zp");
    for (int j = 0; j < NPE; j++) expect_res(j, j, 7, "zp");
    results.delete();
    cfg_zp = 8'd0;

    // Backpressure: consumer stalls 50 cycles while three groups stream in
    bus.in_wgt  = {8'd4, 8'd3, 8'd2, 8'd1};
    bus.out_rdy = 1'b0;
    fork
      begin
        group4(1, 1, 1, 1);
        group4(2, 2, 2, 2);
        group4(3, 3, 3, 3);
      end
      begin
        repeat (50) tick();
        check("bp_in_rdy", 64'(bus.in_rdy), 64'(0));
        check("bp_out_vld", 64'(bus.out_vld), 64'(1));
        check("bp_head_fm", 64'(bus.out_fm), 64'(4));
        check("bp_head_idx", 64'(bus.out_idx), 64'(0));
        check("bp_no_pop", 64'(results.size()), 64'(0));
        bus.out_rdy = 1'b1;
      end
    join
    drain(12, "bp");
    for (int g = 1; g <= 3; g++)
      for (int j = 0; j < NPE; j++)
        expect_res((g - 1) * NPE + j, j, 4 * g * (j + 1), "bp");
    results.delete();

    // Short accumulation L=2 sets sticky err_len
    check("err_pre", 64'(err_len), 64'(0));
    beat(8'd1, 1'b0);
    beat(8'd1, 1'b1);
    check("err_set", 64'(err_len), 64'(1));
    drain(4, "short");
    for (int j = 0; j < NPE; j++) expect_res(j, j, 2 * (j + 1), "short");
    results.delete();
    repeat (10) tick();
    check("err_sticky", 64'(err_len), 64'(1));

    // Reset mid-stream with queued results and a partial group
    bus.out_rdy = 1'b0;
    group4(1, 1, 1, 1);
    beat(8'd5, 1'b0);
    beat(8'd5, 1'b0);
    repeat (4) tick();
    check("pre_rst_out_vld", 64'(bus.out_vld), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out_vld", 64'(bus.out_vld), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_in_rdy", 64'(bus.in_rdy), 64'(1));
    check("mid_rst_err_len", 64'(err_len), 64'(0));
    check("mid_rst_out_fm", 64'(bus.out_fm), 64'(0));
    bus.out_rdy = 1'b1;
    results.delete();
    group4(1, 1, 1, 1);
    drain(4, "post_rst");
    for (int j = 0; j < NPE; j++) expect_res(j, j, 4 * (j + 1), "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
